qspi_slave_if: RTL and testbench

Quad-SPI slave front-end living inside the matrix-multiplier wrapper, directly downstream of the UART-to-QSPI bridge. It oversamples the bridge's chip-select, clock and 4-bit data lines on the system clock and assembles nibbles into bytes. It decodes a one-byte command and issues byte-wide register writes or reads to the multiplier's operand/result register file. On reads it drives result nibbles back toward the bridge.

---
 rtl/qspi_slave_if.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_qspi_slave_if.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_slave_if.sv
// ---------------------------------------------------------------------------
// qspi_slave_if
//
// Quad-SPI slave front-end for the matrix-multiplier register file. The
// bridge-side chip select, clock and data nibble are oversampled on clk,
// nibbles are assembled into bytes (high nibble first, sampled on sck rise),
// and a one-byte command selects a burst of byte writes or byte reads.
//
// Transaction: byte 0 = command. Bit 7 = 1 read, 0 write. Bits [ADDR_W-1:0]
// give the start address. The address increments per byte, modulo 2^ADDR_W.
// Reads insert two dummy sck rises (turnaround). Data is then driven on sck
// falls, high nibble first.
//
// Optional build macro: QSPI_ERR_CNT_EN. When defined, it enables a saturating
// count of aborted transactions on err_cnt. When undefined, err_cnt is tied
// to 0.
//
// Parameters:
//   ADDR_W       register-file address width (<= 7)
//   SYNC_STAGES  flops per input synchronizer (>= 2)
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   qspi_cs_n, qspi_sck   chip select / QSPI clock from the bridge (async)
//   qspi_io_in   [3:0]    nibble from the bridge
//   qspi_io_out  [3:0]    nibble to the bridge
//   qspi_io_oe            high while qspi_io_out is driven
//   wr_valid/addr/data    one-cycle register write strobe
//   rd_req/rd_addr        one-cycle register read strobe
//   rd_data      [7:0]    read data, valid the cycle after rd_req
//   err_cnt      [7:0]    aborted-transaction counter
// ---------------------------------------------------------------------------
module qspi_slave_if #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qspi_cs_n,
    input  logic              qspi_sck,
    input  logic [3:0]        qspi_io_in,
    output logic [3:0]        qspi_io_out,
    output logic              qspi_io_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_TURN,
        ST_RDATA
    } state_e;

    // Pin bundle {cs_n, sck, io[3:0]} at its idle level: deselected, sck low.
    localparam logic [5:0] PIN_IDLE = 6'b10_0000;

    // -----------------------------------------------------------------------
    // Input synchronizers. All six pins share one chain so that the data
    // nibble stays aligned with the sck edge that samples it.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]                  sync_out;

    // NOTE: synchronizer flops are reset to the idle pin levels rather than
    // to zero. Otherwise a cs_n of 0 would show up as a false select right
    // after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{PIN_IDLE}};
        end else begin
            // NOTE: non-blocking assignment keeps every stage sampling the
            // previous stage's old value, so the chain is really SYNC_STAGES
            // deep.
            sync_q <= {sync_q[SYNC_STAGES-2:0], {qspi_cs_n, qspi_sck, qspi_io_in}};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Edge detection. Events are registered together with the data nibble,
    // so that one aligned set of inputs reaches the FSM.
    // -----------------------------------------------------------------------
    logic       cs_prev_q, sck_prev_q;
    logic       sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;
    logic [3:0] nib_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            nib_q      <= 4'h0;
        end else begin
            cs_prev_q  <= sync_out[5];
            sck_prev_q <= sync_out[4];
            sck_rise_q <=  sync_out[4] & ~sck_prev_q;
            sck_fall_q <= ~sync_out[4] &  sck_prev_q;
            cs_rise_q  <=  sync_out[5] & ~cs_prev_q;
            cs_fall_q  <= ~sync_out[5] &  cs_prev_q;
            nib_q      <= sync_out[3:0];
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM
    // -----------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                half_q, half_d;        // first nibble of byte seen
    logic [3:0]          hi_q, hi_d;            // pending high nibble
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                cap_q;                 // rd_data is valid this cycle
    logic [7:0]          shreg_q, shreg_d;
    logic [3:0]          io_out_q, io_out_d;
    logic                io_oe_q, io_oe_d;
    logic                abort;
    logic [7:0]          byte_w;

    // Byte completed by the current sck rise (meaningful when half_q = 1).
    assign byte_w = {hi_q, nib_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_q     <= 1'b0;
            hi_q       <= 4'h0;
            addr_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            cap_q      <= 1'b0;
            shreg_q    <= 8'h00;
            io_out_q   <= 4'h0;
            io_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            cap_q      <= rd_req_q;
            shreg_q    <= shreg_d;
            io_out_q   <= io_out_d;
            io_oe_q    <= io_oe_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case
        // statement. Paths that do not assign a signal then hold the
        // register value, and no latch is inferred.
        state_d    = state_q;
        half_d     = half_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        shreg_d    = cap_q ? rd_data : shreg_q;
        io_out_d   = io_out_q;
        io_oe_d    = io_oe_q;
        abort      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // sck edges are ignored here, which covers sck activity
                // while deselected.
                if (cs_fall_q) begin
                    state_d = ST_CMD;
                    half_d  = 1'b0;
                end
            end

            ST_CMD: begin
                if (sck_rise_q) begin
                    if (!half_q) begin
                        hi_d   = nib_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        addr_d = byte_w[ADDR_W-1:0];
                        if (byte_w[7]) begin
                            state_d   = ST_TURN;
                            rd_req_d  = 1'b1;
                            rd_addr_d = byte_w[ADDR_W-1:0];
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end

            ST_WDATA: begin
                if (sck_rise_q) begin
                    if (!half_q) begin
                        hi_d   = nib_q;
                        half_d = 1'b1;
                    end else begin
                        half_d     = 1'b0;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = byte_w;
                        addr_d     = addr_q + 1'b1;
                    end
                end
            end

            ST_TURN: begin
                // Two dummy rises. half_q counts the first one.
                if (sck_rise_q) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        state_d = ST_RDATA;
                    end
                end
            end

            ST_RDATA: begin
                // Falls drive the nibble the master samples on the next rise.
                // half_q selects high (0) or low (1).
                if (sck_fall_q) begin
                    io_out_d = half_q ? shreg_q[3:0] : shreg_q[7:4];
                    io_oe_d  = 1'b1;
                end
                // Rises advance the nibble phase. The second rise of a byte
                // fetches the next byte, which is captured long before the
                // following fall.
                if (sck_rise_q) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d    = 1'b0;
                        addr_d    = addr_q + 1'b1;
                        rd_req_d  = 1'b1;
                        rd_addr_d = addr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Deselect wins after any byte completed by a coincident rise has
        // been processed above. A leftover half byte is dropped.
        if (cs_rise_q && (state_q != ST_IDLE)) begin
            abort   = half_d || (state_d == ST_CMD) || (state_d == ST_TURN);
            state_d = ST_IDLE;
            half_d  = 1'b0;
            io_oe_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Optional aborted-transaction counter
    // -----------------------------------------------------------------------
`ifdef QSPI_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (abort && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic abort_unused;
    assign abort_unused = abort;
    assign err_cnt      = 8'h00;
`endif

    assign qspi_io_out = io_out_q;
    assign qspi_io_oe  = io_oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_qspi_slave_if.sv
// ---------------------------------------------------------------------------
// tb_qspi_slave_if
//
// Self-checking bench for qspi_slave_if. A behavioural QSPI master drives
// transactions. Expected writes, read nibbles and read-request addresses come
// from the command/data bytes with plain arithmetic. A register-file model
// (mem) supplies rd_data. Directed cases come first, then random bursts.
// ---------------------------------------------------------------------------
module tb_qspi_slave_if;

    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int NADDR       = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              qspi_cs_n;
    logic              qspi_sck;
    logic [3:0]        qspi_io_in;
    logic [3:0]        qspi_io_out;
    logic              qspi_io_oe;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        err_cnt;

    qspi_slave_if #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .qspi_cs_n   (qspi_cs_n),
        .qspi_sck    (qspi_sck),
        .qspi_io_in  (qspi_io_in),
        .qspi_io_out (qspi_io_out),
        .qspi_io_oe  (qspi_io_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                last_rise = 0;
    int                last_fall = 0;
    int                exp_err = 0;
    logic [7:0]        mem [NADDR];
    logic [7:0]        data_buf [8];
    wr_t               wr_q [$];
    logic [ADDR_W-1:0] rd_q [$];
    logic              prev_wr = 1'b0;
    logic              prev_oe = 1'b0;

    // Register-file read port: data follows rd_addr, so it is valid on the
    // cycle after rd_req.
    assign rd_data = mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                wr_q.push_back('{a: wr_addr, d: wr_data});
                check("wr_latency", cyc - last_rise, LAT);
                check("wr_spacing", prev_wr, 1'b0);
            end
            if (rd_req) rd_q.push_back(rd_addr);
            if (qspi_io_oe && !prev_oe) check("oe_latency", cyc - last_fall, LAT);
            prev_wr <= wr_valid;
            prev_oe <= qspi_io_oe;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- master driver ----------------
    task automatic half_wait();
        repeat ($urandom_range(5, 8)) @(negedge clk);
    endtask

    task automatic clock_nibble(input logic [3:0] n, output logic [3:0] rx, output logic rx_oe);
        qspi_io_in = n;
        half_wait();
        rx       = qspi_io_out;
        rx_oe    = qspi_io_oe;
        qspi_sck = 1'b1;
        last_rise = cyc;
        half_wait();
        qspi_sck  = 1'b0;
        last_fall = cyc;
    endtask

    task automatic cs_low();
        @(negedge clk);
        qspi_cs_n = 1'b0;
        half_wait();
    endtask

    task automatic cs_high();
        half_wait();
        qspi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Full transaction: a command plus nbytes of data (writes use data_buf).
    task automatic do_txn(input logic [7:0] cmd, input int nbytes);
        logic [3:0] rx;
        logic       rx_oe;
        logic [7:0] exp;
        int         base;
        base = int'(cmd) % NADDR;
        wr_q.delete();
        rd_q.delete();
        cs_low();
        clock_nibble(cmd[7:4], rx, rx_oe);
        clock_nibble(cmd[3:0], rx, rx_oe);
        if (cmd[7]) begin
            clock_nibble(4'h0, rx, rx_oe);
            clock_nibble(4'h0, rx, rx_oe);
            for (int i = 0; i < nbytes; i++) begin
                exp = mem[(base + i) % NADDR];
                clock_nibble(4'h0, rx, rx_oe);
                check("rd_nib_hi", rx, exp[7:4]);
                check("rd_oe", rx_oe, 1'b1);
                clock_nibble(4'h0, rx, rx_oe);
                check("rd_nib_lo", rx, exp[3:0]);
            end
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                exp = data_buf[i];
                clock_nibble(exp[7:4], rx, rx_oe);
                clock_nibble(exp[3:0], rx, rx_oe);
            end
        end
        cs_high();
        if (cmd[7]) begin
            check("rd_no_writes", wr_q.size(), 0);
            check("rd_req_count", (rd_q.size() == nbytes) || (rd_q.size() == nbytes + 1), 1);
            for (int i = 0; i < nbytes && i < rd_q.size(); i++)
                check("rd_req_addr", rd_q[i], (base + i) % NADDR);
        end else begin
            check("wr_count", wr_q.size(), nbytes);
            check("wr_no_rd_req", rd_q.size(), 0);
            for (int i = 0; i < nbytes && i < wr_q.size(); i++) begin
                check("wr_addr", wr_q[i].a, (base + i) % NADDR);
                check("wr_data", wr_q[i].d, data_buf[i]);
            end
        end
        check("oe_after_cs", qspi_io_oe, 1'b0);
        check("err_cnt", err_cnt, exp_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_io_out"}, qspi_io_out, 4'h0);
        check({tag, "_io_oe"}, qspi_io_oe, 1'b0);
        check({tag, "_wr_valid"}, wr_valid, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 8'h00);
        check({tag, "_rd_req"}, rd_req, 1'b0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_err_cnt"}, err_cnt, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rx;
        logic       rx_oe;

        rst_n      = 1'b0;
        qspi_cs_n  = 1'b1;
        qspi_sck   = 1'b0;
        qspi_io_in = 4'h0;
        for (int i = 0; i < NADDR; i++) mem[i] = 8'($urandom);
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst.
        data_buf[0] = 8'hA5; data_buf[1] = 8'h5A;
        do_txn(8'h03, 2);

        // Write with address wrap 15 -> 0.
        data_buf[0] = 8'h11; data_buf[1] = 8'h22;
        do_txn(8'h0F, 2);

        // Read of two bytes.
        mem[2] = 8'hC3; mem[3] = 8'h7E;
        do_txn(8'h82, 2);

        // Read across the wrap boundary.
        mem[15] = 8'h9D; mem[0] = 8'h41;
        do_txn(8'h8F, 2);

        // Abort: cs rises after one nibble of a data byte.
        wr_q.delete();
        cs_low();
        clock_nibble(4'h0, rx, rx_oe);
        clock_nibble(4'h5, rx, rx_oe);
        clock_nibble(4'hA, rx, rx_oe);
        cs_high();
`ifdef QSPI_ERR_CNT_EN
        exp_err++;
`endif
        check("abort_no_strobe", wr_q.size(), 0);
        check("abort_oe", qspi_io_oe, 1'b0);
        check("abort_err_cnt", err_cnt, exp_err);

        // cs rises together with the byte-completing sck rise.
        wr_q.delete();
        cs_low();
        clock_nibble(4'h0, rx, rx_oe);
        clock_nibble(4'h6, rx, rx_oe);
        clock_nibble(4'h3, rx, rx_oe);
        qspi_io_in = 4'hC;
        half_wait();
        qspi_sck  = 1'b1;
        qspi_cs_n = 1'b1;
        last_rise = cyc;
        half_wait();
        qspi_sck = 1'b0;
        repeat (8) @(negedge clk);
        check("coinc_count", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check("coinc_addr", wr_q[0].a, 6);
            check("coinc_data", wr_q[0].d, 8'h3C);
        end
        check("coinc_err_cnt", err_cnt, exp_err);

        // Noise: sck activity while deselected.
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < 8; i++) begin
            qspi_io_in = 4'($urandom);
            repeat (5) @(negedge clk);
            qspi_sck = ~qspi_sck;
        end
        repeat (8) @(negedge clk);
        check("noise_wr", wr_q.size(), 0);
        check("noise_rd", rd_q.size(), 0);
        check("noise_oe", qspi_io_oe, 1'b0);
        data_buf[0] = 8'h6B;
        do_txn(8'h07, 1);

        // Async reset mid-read.
        mem[4] = 8'hE2; mem[5] = 8'h18;
        cs_low();
        clock_nibble(4'h8, rx, rx_oe);
        clock_nibble(4'h4, rx, rx_oe);
        clock_nibble(4'h0, rx, rx_oe);
        clock_nibble(4'h0, rx, rx_oe);
        clock_nibble(4'h0, rx, rx_oe);
        repeat (6) @(negedge clk);
        check("midrd_oe_before", qspi_io_oe, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrd_reset");
        qspi_cs_n = 1'b1;
        qspi_sck  = 1'b0;
        exp_err   = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        data_buf[0] = 8'h99;
        do_txn(8'h01, 1);

        // Random bursts.
        for (int t = 0; t < 20; t++) begin
            logic [7:0] cmd;
            int         n;
            cmd = {1'($urandom), 3'($urandom), 4'($urandom)};
            n   = $urandom_range(1, 4);
            for (int i = 0; i < NADDR; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 8; i++) data_buf[i] = 8'($urandom);
            do_txn(cmd, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
